alu_packet_ctrl: RTL
====================

Name: alu_packet_ctrl

Overview:
Packet sequencer between the UART receive/transmit byte streams and the ALU datapath on the iCE40 UART-ALU design.
- Parses framed command packets from the UART RX stream.
- Performs 32-bit add itself; sequences an external multiplier for mul.
- Streams the 32-bit result, or echoed payload bytes, back to the UART TX stream.

Parameters:
OPCODE_ECHO_P, 8'hEC, opcode for echo packets
OPCODE_ADD_P, 8'hAD, opcode for 32-bit accumulate-add packets
OPCODE_MUL_P, 8'h88, opcode for 32-bit accumulate-multiply packets

Ports:
clk  in  1  system clock; the only clock
rst  in  1  asynchronous, active-high reset
rx_tdata_i  in  8  byte from UART receiver
rx_tvalid_i  in  1  rx byte valid
rx_tready_o  out  1  controller accepts rx byte
tx_tdata_o  out  8  byte to UART transmitter
tx_tvalid_o  out  1  tx byte valid
tx_tready_i  in  1  transmitter accepts byte
mul_a_o  out  32  multiplier operand A (running product)
mul_b_o  out  32  multiplier operand B (new operand)
mul_valid_o  out  1  multiply request
mul_ready_i  in  1  multiplier accepts request
mul_result_i  in  32  product, low 32 bits
mul_result_valid_i  in  1  one-cycle product strobe
busy_o  out  1  packet in progress (state != HDR_OP)
err_o  out  1  one-cycle pulse on a malformed packet

Behaviour:
- Reset is asynchronous and active-high. While rst is high, all outputs are 0, state is HDR_OP and the accumulator is 0.
- Handshakes:
  - A transfer occurs on a cycle where valid and ready are both high.
  - tx_tvalid_o and tx_tdata_o stay stable until accepted.
  - mul_valid_o, mul_a_o and mul_b_o stay stable until mul_ready_i.
- Packet format: opcode, reserved, LEN[7:0], LEN[15:8], then payload.
  - LEN is the total packet length including the 4-byte header.
  - Operands are 32-bit little-endian.
- States:
  - HDR_OP: rx_tready_o=1. Latch the opcode and go to HDR_RSV.
  - HDR_RSV: rx_tready_o=1. Discard the byte and go to HDR_LEN0.
  - HDR_LEN0, HDR_LEN1: rx_tready_o=1. Latch LEN; the remaining count is LEN-4. Validate on the LEN[15:8] transfer:
    - LEN<4: err pulse, go to HDR_OP.
    - Unknown opcode: err pulse, go to DRAIN.
    - Add/mul with LEN<8 or (LEN-4)%4!=0: err pulse, go to DRAIN.
    - Echo with LEN==4: go to HDR_OP.
    - Otherwise go to ECHO or OPERAND.
  - ECHO:
    - rx_tready_o = !tx_tvalid_o || tx_tready_i.
    - A byte accepted in cycle N appears on tx_tdata_o with tx_tvalid_o in cycle N+1.
    - After the last byte is accepted, go to FLUSH. FLUSH waits for the tx holding register to empty, then goes to HDR_OP.
  - OPERAND:
    - rx_tready_o=1. Assemble 4 bytes LSB first.
    - On the 4th byte, for add: acc <= acc + operand, mod 2^32.
    - On the 4th byte, for mul:
      - First operand: acc <= operand.
      - Later operands: go to MUL_REQ with mul_a_o=acc and mul_b_o=operand.
    - After the last operand completes, go to RESP.
  - MUL_REQ: rx_tready_o=0, mul_valid_o=1. On mul_ready_i go to MUL_WAIT.
  - MUL_WAIT: on mul_result_valid_i, acc <= mul_result_i. Return to OPERAND, or go to RESP if no operands remain.
  - RESP:
    - rx_tready_o=0. Send acc as 4 bytes, LSB first.
    - After the 4th byte is accepted: acc <= 0, go to HDR_OP.
    - The first response byte is valid the cycle after the final operand byte (add) or the result strobe (mul).
  - DRAIN: rx_tready_o=1. Discard the remaining count of bytes, then go to HDR_OP. The count reaching 0 exits DRAIN.
- A single-operand mul returns that operand with no multiplier request.
- rx_tready_o=0 in MUL_REQ, MUL_WAIT, RESP and FLUSH, so the RX FIFO absorbs the following packet.
- err_o is high for exactly the cycle after the failing LEN[15:8] transfer.
- mul_result_valid_i outside MUL_WAIT is ignored.
- Reset mid-packet aborts immediately. The next byte after reset is parsed as an opcode.

Test Plan:
1. Add: rx AD 00 0C 00 01 00 00 00 02 00 00 00 -> tx 03 00 00 00. No err; busy_o low afterwards.
2. Add wrap: AD 00 0C 00 FF FF FF FF 02 00 00 00 -> tx 01 00 00 00.
3. Mul: 88 00 10 00 with operands 2, 3, 7; model has mul_ready_i after 2 cycles and result after 5 cycles -> two requests (A=2,B=3; A=6,B=7), tx 2A 00 00 00. mul_a_o and mul_b_o stay stable while waiting.
4. Echo: EC 00 07 00 61 62 63 with tx_tready_i toggling each cycle -> tx 61 62 63 in order, no duplicates or losses. rx_tready_o is never high while the holding register is full and stalled.
5. Errors:
   - 55 00 08 00 + 4 bytes -> one err pulse, no tx, the 4 bytes are drained.
   - AD 00 09 00 + 5 bytes -> err, drained.
   - After both, AD 00 08 00 05 00 00 00 -> tx 05 00 00 00.
6. Reset mid-MUL_WAIT: assert rst for 3 cycles -> all outputs 0 asynchronously. A later add packet returns the correct sum, unaffected by the stale acc.

Source files
------------

// File: rtl/alu_packet_ctrl.sv
// Packet sequencer between the UART byte streams and the ALU datapath.
// Parses framed commands, accumulates add/mul results, and streams responses or echoes.
module alu_packet_ctrl #(
  parameter logic [7:0] OPCODE_ECHO_P = 8'hEC,
  parameter logic [7:0] OPCODE_ADD_P  = 8'hAD,
  parameter logic [7:0] OPCODE_MUL_P  = 8'h88
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_tdata_i,
  input  logic        rx_tvalid_i,
  output logic        rx_tready_o,
  output logic [7:0]  tx_tdata_o,
  output logic        tx_tvalid_o,
  input  logic        tx_tready_i,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_valid_o,
  input  logic        mul_ready_i,
  input  logic [31:0] mul_result_i,
  input  logic        mul_result_valid_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned MIN_ARITH = 8;

  typedef enum logic [3:0] {
    HDR_OP,
    HDR_RSV,
    HDR_LEN0,
    HDR_LEN1,
    ECHO,
    FLUSH,
    OPERAND,
    MUL_REQ,
    MUL_WAIT,
    RESP,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [BYTE_W-1:0]        opcode_q;
  logic [BYTE_W-1:0]        len_lo_q;
  logic [BYTE_W-1:0]        tx_data_q;
  logic                     tx_valid_q;
  logic [LEN_W-1:0]         rem_q;
  logic [WORD_W-1:0]        acc_q;
  logic [WORD_W-1:0]        mul_a_q;
  logic [WORD_W-1:0]        mul_b_q;
  logic [WORD_W-BYTE_W-1:0] opnd_q;
  logic [1:0]               byte_idx_q;
  logic [1:0]               resp_idx_q;
  logic                     first_q;
  logic                     err_q;

  logic              rx_ready_c;
  logic              hdr_err_c;
  logic              rx_fire;
  logic              tx_fire;
  logic [LEN_W-1:0]  len_full;
  logic [WORD_W-1:0] operand_full;
  logic [WORD_W-1:0] add_sum;
  logic [1:0]        resp_nxt;
  logic              is_echo;
  logic              is_add;
  logic              is_mul;
  logic              len_short;
  logic              arith_bad;
  logic              last_byte;
  logic              word_done;

  assign is_echo      = (opcode_q == OPCODE_ECHO_P);
  assign is_add       = (opcode_q == OPCODE_ADD_P);
  assign is_mul       = (opcode_q == OPCODE_MUL_P);
  assign len_full     = {rx_tdata_i, len_lo_q};
  assign len_short    = (len_full < LEN_W'(HDR_BYTES));
  // Payload must be whole 32-bit words; LEN%4 equals (LEN-4)%4.
  assign arith_bad    = (is_add | is_mul) &
                        ((len_full < LEN_W'(MIN_ARITH)) | (len_full[1:0] != 2'b00));
  assign operand_full = {rx_tdata_i, opnd_q};
  assign add_sum      = acc_q + operand_full;
  assign rx_fire      = rx_tvalid_i & rx_tready_o;
  assign tx_fire      = tx_valid_q & tx_tready_i;
  assign last_byte    = (rem_q == LEN_W'(1));
  assign word_done    = rx_fire & (byte_idx_q == 2'd3);
  assign resp_nxt     = resp_idx_q + 2'd1;

  assign rx_tready_o  = rx_ready_c & ~rst;
  assign tx_tdata_o   = tx_data_q;
  assign tx_tvalid_o  = tx_valid_q;
  assign mul_a_o      = mul_a_q;
  assign mul_b_o      = mul_b_q;
  assign mul_valid_o  = (state_q == MUL_REQ);
  assign busy_o       = (state_q != HDR_OP);
  assign err_o        = err_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HDR_OP;
    else     state_q <= state_d;
  end

  // Next state, rx acceptance and header validation
  always_comb begin
    state_d    = state_q;
    rx_ready_c = 1'b0;
    hdr_err_c  = 1'b0;
    case (state_q)
      HDR_OP: begin
        rx_ready_c = 1'b1;
        if (rx_fire) state_d = HDR_RSV;
      end
      HDR_RSV: begin
        rx_ready_c = 1'b1;
        if (rx_fire) state_d = HDR_LEN0;
      end
      HDR_LEN0: begin
        rx_ready_c = 1'b1;
        if (rx_fire) state_d = HDR_LEN1;
      end
      HDR_LEN1: begin
        rx_ready_c = 1'b1;
        if (rx_fire) begin
          if (len_short) begin
            hdr_err_c = 1'b1;
            state_d   = HDR_OP;
          end else if (!(is_echo | is_add | is_mul) || arith_bad) begin
            hdr_err_c = 1'b1;
            state_d   = DRAIN;
          end else if (is_echo) begin
            state_d = (len_full == LEN_W'(HDR_BYTES)) ? HDR_OP : ECHO;
          end else begin
            state_d = OPERAND;
          end
        end
      end
      ECHO: begin
        rx_ready_c = ~tx_valid_q | tx_tready_i;
        if (rx_fire && last_byte) state_d = FLUSH;
      end
      FLUSH: begin
        if (!tx_valid_q || tx_tready_i) state_d = HDR_OP;
      end
      OPERAND: begin
        rx_ready_c = 1'b1;
        if (word_done) begin
          if (is_mul && !first_q) state_d = MUL_REQ;
          else if (last_byte)     state_d = RESP;
        end
      end
      MUL_REQ: begin
        if (mul_ready_i) state_d = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mul_result_valid_i) state_d = (rem_q == '0) ? RESP : OPERAND;
      end
      RESP: begin
        if (tx_fire && resp_idx_q == 2'd3) state_d = HDR_OP;
      end
      DRAIN: begin
        // A zero drain count leaves without touching the rx stream.
        rx_ready_c = (rem_q != '0);
        if (rem_q == '0 || (rx_fire && last_byte)) state_d = HDR_OP;
      end
      default: state_d = HDR_OP;
    endcase
  end

  // Datapath: header fields, accumulator, tx holding register, multiplier operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q   <= '0;
      len_lo_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rem_q      <= '0;
      acc_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      opnd_q     <= '0;
      byte_idx_q <= '0;
      resp_idx_q <= '0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= hdr_err_c;
      if (tx_fire) tx_valid_q <= 1'b0;
      case (state_q)
        HDR_OP: begin
          if (rx_fire) begin
            opcode_q   <= rx_tdata_i;
            first_q    <= 1'b1;
            byte_idx_q <= '0;
          end
        end
        HDR_LEN0: begin
          if (rx_fire) len_lo_q <= rx_tdata_i;
        end
        HDR_LEN1: begin
          if (rx_fire) rem_q <= len_full - LEN_W'(HDR_BYTES);
        end
        ECHO: begin
          if (rx_fire) begin
            tx_data_q  <= rx_tdata_i;
            tx_valid_q <= 1'b1;
            rem_q      <= rem_q - LEN_W'(1);
          end
        end
        OPERAND: begin
          if (rx_fire) begin
            rem_q      <= rem_q - LEN_W'(1);
            byte_idx_q <= byte_idx_q + 2'd1;
            opnd_q     <= {rx_tdata_i, opnd_q[WORD_W-BYTE_W-1:BYTE_W]};
          end
          if (word_done) begin
            if (is_add) begin
              acc_q <= add_sum;
              if (last_byte) begin
                tx_data_q  <= add_sum[BYTE_W-1:0];
                tx_valid_q <= 1'b1;
                resp_idx_q <= '0;
              end
            end else if (first_q) begin
              acc_q   <= operand_full;
              first_q <= 1'b0;
              if (last_byte) begin
                tx_data_q  <= operand_full[BYTE_W-1:0];
                tx_valid_q <= 1'b1;
                resp_idx_q <= '0;
              end
            end else begin
              mul_a_q <= acc_q;
              mul_b_q <= operand_full;
            end
          end
        end
        MUL_WAIT: begin
          if (mul_result_valid_i) begin
            acc_q <= mul_result_i;
            if (rem_q == '0) begin
              tx_data_q  <= mul_result_i[BYTE_W-1:0];
              tx_valid_q <= 1'b1;
              resp_idx_q <= '0;
            end
          end
        end
        RESP: begin
          if (tx_fire) begin
            if (resp_idx_q == 2'd3) begin
              acc_q <= '0;
            end else begin
              tx_data_q  <= acc_q[{resp_nxt, 3'b000} +: BYTE_W];
              tx_valid_q <= 1'b1;
              resp_idx_q <= resp_nxt;
            end
          end
        end
        DRAIN: begin
          if (rx_fire) rem_q <= rem_q - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
